// File: rtl/checker_sched_pkg.sv
// Shared types for the auto-mode checker scheduler: FSM state encoding and
// the channel-pointer width helper.
package checker_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SELECT      = 3'd1,
    ST_START       = 3'd2,
    ST_WAIT_END    = 3'd3,
    ST_ABORT       = 3'd4,
    ST_WAIT_PERIOD = 3'd5
  } state_t;

  // A single-channel build still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/checker_downcnt.sv
// Loadable down-counter that saturates at zero; used for the inter-round
// period and the per-check timeout.
module checker_downcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/checker_sched.sv
// Auto-mode scheduler: round-robins integrity checks over the enabled host
// pages through the single-check engine and keeps sticky per-channel results.
module checker_sched
  import checker_sched_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int PERIOD_W = 32,
  parameter int TMO_W    = 24
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    cfg_en,
  input  logic [NCHAN-1:0]        cfg_mask,
  input  logic [NCHAN*ADDR_W-1:0] cfg_addr,
  input  logic [PERIOD_W-1:0]     cfg_period,
  input  logic [TMO_W-1:0]        cfg_timeout,
  output logic                    chk_start,
  output logic [ADDR_W-1:0]       chk_addr,
  output logic                    chk_rst,
  input  logic                    chk_end,
  input  logic                    chk_error,
  input  logic [DATA_W-1:0]       chk_data,
  output logic [NCHAN-1:0]        res_valid,
  output logic [NCHAN-1:0]        res_error,
  output logic [NCHAN-1:0]        res_timeout,
  output logic [NCHAN-1:0]        res_overrun,
  output logic [NCHAN*DATA_W-1:0] res_data,
  input  logic [NCHAN-1:0]        res_ack,
  output logic                    irq,
  output logic                    busy,
  output logic [15:0]             round_cnt
);

  localparam int PTR_W = ptr_width(NCHAN);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NCHAN - 1);

  state_t           state, next_state;
  logic [PTR_W-1:0] ptr;
  logic             at_last, done, take_sel, capture, abort_res;
  logic             ptr_inc, ptr_clr, round_end;
  logic             tmo_on, tmo_zero, per_zero;
  logic             load_per, per_dec, tmo_dec;
  logic             start_d, rst_d, busy_d;
  logic [NCHAN-1:0] valid_n, error_n, tmo_n, ovr_n;

  assign at_last = (ptr == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Finishing a channel (result, abort or skip) shares one advance/round-end path.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    take_sel   = 1'b0;
    capture    = 1'b0;
    abort_res  = 1'b0;
    ptr_inc    = 1'b0;
    ptr_clr    = 1'b0;
    round_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        ptr_clr = 1'b1;
        if (cfg_en) next_state = ST_SELECT;
      end
      ST_SELECT: begin
        if (!cfg_en) begin
          next_state = ST_IDLE;
        end else if (cfg_mask[ptr]) begin
          take_sel   = 1'b1;
          next_state = ST_START;
        end else begin
          done = 1'b1;
        end
      end
      ST_START: next_state = ST_WAIT_END;
      ST_WAIT_END: begin
        if (chk_end) begin
          capture = 1'b1;
          done    = 1'b1;
        end else if (tmo_on && tmo_zero) begin
          next_state = ST_ABORT;
        end
      end
      ST_ABORT: begin
        abort_res = 1'b1;
        done      = 1'b1;
      end
      ST_WAIT_PERIOD: begin
        if (!cfg_en) next_state = ST_IDLE;
        else if (per_zero) next_state = ST_SELECT;
      end
      default: next_state = ST_IDLE;
    endcase
    if (done) begin
      if (at_last) round_end = 1'b1;
      else ptr_inc = 1'b1;
      if (!cfg_en) next_state = ST_IDLE;
      else if (!at_last || (cfg_period == '0)) next_state = ST_SELECT;
      else next_state = ST_WAIT_PERIOD;
    end
  end

  always_comb begin
    start_d  = (state == ST_START);
    rst_d    = (next_state == ST_ABORT);
    busy_d   = (next_state != ST_IDLE);
    load_per = round_end;
    per_dec  = (state == ST_WAIT_PERIOD);
    tmo_dec  = (state == ST_START) || (state == ST_WAIT_END);
  end

  // The period counter is loaded with N-1 so WAIT_PERIOD lasts exactly N cycles.
  checker_downcnt #(.W(PERIOD_W)) u_period (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .load  (load_per),
    .value (cfg_period - PERIOD_W'(1)),
    .dec   (per_dec),
    .zero  (per_zero)
  );

  checker_downcnt #(.W(TMO_W)) u_timeout (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .load  (take_sel),
    .value (cfg_timeout),
    .dec   (tmo_dec),
    .zero  (tmo_zero)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr       <= '0;
      chk_addr  <= '0;
      tmo_on    <= 1'b0;
      round_cnt <= '0;
      chk_start <= 1'b0;
      chk_rst   <= 1'b0;
      busy      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ptr_clr || round_end) ptr <= '0;
      else if (ptr_inc) ptr <= ptr + PTR_W'(1);
      if (take_sel) begin
        chk_addr <= cfg_addr[int'(ptr)*ADDR_W +: ADDR_W];
        tmo_on   <= (cfg_timeout != '0);
      end
      if (round_end) round_cnt <= round_cnt + 16'd1;
      chk_start <= start_d;
      chk_rst   <= rst_d;
      busy      <= busy_d;
      irq       <= |(valid_n & (error_n | tmo_n));
    end
  end

  // A new result for a channel overrides a same-cycle ack for that channel.
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic              hit;
    logic              valid_q, error_q, tmo_q, ovr_q;
    logic [DATA_W-1:0] data_q;

    assign hit        = (capture || abort_res) && (ptr == PTR_W'(i));
    assign valid_n[i] = hit | (valid_q & ~res_ack[i]);
    assign error_n[i] = hit ? (capture & chk_error) : (error_q & ~res_ack[i]);
    assign tmo_n[i]   = hit ? abort_res : (tmo_q & ~res_ack[i]);
    assign ovr_n[i]   = hit ? (ovr_q | valid_q) : (ovr_q & ~res_ack[i]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        valid_q <= 1'b0;
        error_q <= 1'b0;
        tmo_q   <= 1'b0;
        ovr_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_n[i];
        error_q <= error_n[i];
        tmo_q   <= tmo_n[i];
        ovr_q   <= ovr_n[i];
        if (hit) data_q <= capture ? chk_data : '0;
      end
    end

    assign res_valid[i]                  = valid_q;
    assign res_error[i]                  = error_q;
    assign res_timeout[i]                = tmo_q;
    assign res_overrun[i]                = ovr_q;
    assign res_data[i*DATA_W +: DATA_W]  = data_q;
  end

endmodule

// File: doc/checker_sched.md
# checker_sched

Parametrised auto-mode scheduler for the checker: round-robins integrity checks over up to NCHAN host pages, one at a time, through the single-check engine (start/end/error handshake). Each check has a programmable timeout, with an engine abort when it expires. Per-channel results are kept until software acknowledges them, and rounds repeat after a programmable idle period. It sits between the control interface and the single-check engine, in the slot the `CHECKER_MODE_AUTO` outputs currently tie off.

## Interface
- NCHAN, 4, number of channels (1..16)
- ADDR_W, 64, page address width
- DATA_W, 64, check result width
- PERIOD_W, 32, inter-round period counter width
- TMO_W, 24, per-check timeout counter width

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  1  auto mode enable (level)
- cfg_mask  in  NCHAN  channel enable mask
- cfg_addr  in  NCHAN*ADDR_W  page address per channel; channel i is at [i*ADDR_W +: ADDR_W]
- cfg_period  in  PERIOD_W  idle cycles between the end of one round and the start of the next
- cfg_timeout  in  TMO_W  WAIT_END cycles before abort; 0 disables the timeout
- chk_start  out  1  one-cycle start pulse to the engine
- chk_addr  out  ADDR_W  page address, valid from chk_start until the check ends
- chk_rst  out  1  one-cycle engine abort pulse
- chk_end  in  1  engine done
- chk_error  in  1  engine error, qualified by chk_end
- chk_data  in  DATA_W  engine result, qualified by chk_end
- res_valid  out  NCHAN  sticky: result present
- res_error  out  NCHAN  sticky: engine reported an error
- res_timeout  out  NCHAN  sticky: check aborted by timeout
- res_overrun  out  NCHAN  sticky: result overwritten while still valid
- res_data  out  NCHAN*DATA_W  last result per channel
- res_ack  in  NCHAN  clears valid/error/timeout/overrun for each set bit
- irq  out  1  level: OR over i of res_valid[i] & (res_error[i] | res_timeout[i])
- busy  out  1  state is not IDLE
- round_cnt  out  16  completed rounds, wraps at 0xFFFF to 0

## Operation
- States: IDLE, SELECT, START, WAIT_END, ABORT, WAIT_PERIOD. Channel pointer ptr.
- IDLE: cfg_en=1 → SELECT with ptr=0.
- SELECT: evaluates one channel per cycle.
  - cfg_en=0 → IDLE.
  - cfg_mask[ptr]=1 → START; chk_addr latched from cfg_addr[ptr].
  - Otherwise advance ptr.
  - Leaving channel NCHAN-1 without a start ends the round.
- Round end: round_cnt++, ptr←0; then WAIT_PERIOD loaded with cfg_period, or SELECT directly when cfg_period=0.
- START: chk_start=1 for one cycle; timeout counter←cfg_timeout; → WAIT_END.
- WAIT_END:
  - chk_end=1: res_data[ptr]←chk_data, res_error[ptr]←chk_error, res_timeout[ptr]←0, res_valid[ptr]←1. If res_valid[ptr] was already 1, res_overrun[ptr]←1. Then advance ptr, or end the round if ptr=NCHAN-1.
  - Timeout counter reaches 0 (cfg_timeout≠0) without chk_end → ABORT.
- ABORT: chk_rst=1 for one cycle; res_timeout[ptr]←1, res_error[ptr]←0, res_valid[ptr]←1, res_data[ptr]←0, overrun rule as above; advance as above.
- WAIT_PERIOD: decrement the counter; reaching 0 → SELECT. cfg_en=0 → IDLE immediately.
- cfg_en=0 during START/WAIT_END: the current check finishes normally (end or timeout), then → IDLE; no abort.
- Boundary rules:
  - chk_end and timeout expiry in the same cycle: chk_end wins.
  - res_ack[i] in the same cycle as a new result for i: the new result wins; overrun is computed before the ack.
  - chk_end outside WAIT_END: ignored.
  - cfg_mask is sampled in SELECT; cfg_addr only at the SELECT→START edge.
  - cfg_mask=0 with cfg_en=1: rounds complete in NCHAN cycles each and round_cnt still counts.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, ptr=0, all outputs 0, all counters 0.
- All outputs are registered (Moore).
- cfg_en sampled high at edge k with cfg_mask[0]=1: SELECT after k, START after k+1, chk_start high in cycle k+2..k+3.
- chk_end sampled at edge m: res_valid/irq updated after m; next chk_start no earlier than m+2.
- Timeout: abort when chk_end is still absent after exactly cfg_timeout WAIT_END cycles; chk_rst high the following cycle.
- Period: exactly cfg_period cycles in WAIT_PERIOD.

## Structure
- checker.vh: state encodings `CHECKER_SCHED_IDLE`..`CHECKER_SCHED_WAIT_PERIOD` (3 bits).
- Sub-module checker_downcnt (parameter W; load, dec, zero), instantiated twice: period (PERIOD_W) and timeout (TMO_W).
- Per-channel result registers via generate loop.

## Test plan
- NCHAN=4, mask=4'b0101, period=10, engine replies chk_end 5 cycles after start with data=ch*0x11 → starts at ch0 and ch2 only; res_data[0]=0x00, res_data[2]=0x22; round_cnt=1; next chk_start 10 cycles after round end.
- timeout=8, engine never replies on ch1 → chk_rst pulse 8 cycles into WAIT_END; res_timeout[1]=1, res_data[1]=0, irq=1; res_ack=4'b0010 → irq=0.
- chk_error=1 with chk_end on ch3 → res_error[3]=1, irq=1; a second round without ack → res_overrun[3]=1.
- chk_end in the same cycle the timeout expires → normal result, no chk_rst.
- cfg_en dropped mid-WAIT_END → check completes, busy=0 one cycle after the result; cfg_en dropped in WAIT_PERIOD → IDLE next cycle.
- sys_rst_n asserted in WAIT_END → all outputs 0 immediately; after release with cfg_en=1, restart at ch0.
